dmem_responder: RTL

//  Data-memory responder on the far side of the MEM-stage load/store interface.
//  - Accepts word read/write requests: MemRead/MemWrite, byte ADDRESS, WRITE_DATA.
//  - Inserts a configurable number of wait states, then returns READ_DATA with a response strobe.
//  - Drives mem_busy so the pipeline holds MEM and earlier stages until the access completes.
//  - Owns the word-addressed storage array; rejects misaligned requests without side effects.

---
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data memory that sits behind the MEM-stage
//               load/store interface. It inserts a fixed number of wait
//               states before each access completes, stalls the pipeline
//               while the access is in progress, and rejects misaligned
//               requests without touching the array.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [31:0]           ADDRESS,
   input  logic [DATA_WIDTH-1:0] WRITE_DATA,
   output logic [DATA_WIDTH-1:0] READ_DATA,
   output logic                  rsp_valid,
   output logic                  mem_busy,
   output logic                  misaligned,
   output logic                  req_conflict
);

   localparam int        DEPTH         = 2 ** ADDR_WIDTH;
   localparam logic [3:0] C_WAIT_STATES = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    is_write_q, is_write_d;
   logic                    conflict_q, conflict_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    misaligned_q, misaligned_d;
   logic                    req_conflict_q, req_conflict_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    w_req;
   logic                    w_valid;
   logic [ADDR_WIDTH-1:0]   w_addr_idx;
   logic                    w_fire;
   logic                    w_mem_we;
   logic                    w_mem_busy;
   logic                    w_unused_addr;

   assign w_req         = MemRead | MemWrite;
   assign w_valid       = w_req & (ADDRESS[1:0] == 2'b00);
   assign w_addr_idx    = ADDRESS[ADDR_WIDTH+1:2];
   // Address bits above the word index wrap the array and are deliberately dropped.
   assign w_unused_addr = ^ADDRESS[31:ADDR_WIDTH+2];

   // Next-state, request capture and completion (array access on the edge entering RESP).
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      is_write_d     = is_write_q;
      conflict_d     = conflict_q;
      idx_d          = idx_q;
      wdata_d        = wdata_q;
      read_data_d    = read_data_q;
      rsp_valid_d    = 1'b0;
      misaligned_d   = 1'b0;
      req_conflict_d = 1'b0;
      w_fire         = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_busy     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_valid) begin
               w_mem_busy = 1'b1;
               is_write_d = MemWrite;
               conflict_d = MemRead & MemWrite;
               idx_d      = w_addr_idx;
               wdata_d    = WRITE_DATA;
               cnt_d      = C_WAIT_STATES;
               if (C_WAIT_STATES == 4'd0) begin
                  state_d = S_RESP;
                  w_fire  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (w_req) begin
               misaligned_d = 1'b1;
            end
         end
         S_WAIT: begin
            w_mem_busy = 1'b1;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               w_fire  = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // With zero wait states the access completes straight from IDLE, so use the _d copies.
      if (w_fire) begin
         rsp_valid_d    = 1'b1;
         req_conflict_d = conflict_d;
         if (is_write_d) begin
            w_mem_we = 1'b1;
         end else begin
            read_data_d = mem_q[idx_d];
         end
      end
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         is_write_q     <= 1'b0;
         conflict_q     <= 1'b0;
         idx_q          <= '0;
         wdata_q        <= '0;
         read_data_q    <= '0;
         rsp_valid_q    <= 1'b0;
         misaligned_q   <= 1'b0;
         req_conflict_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         is_write_q     <= is_write_d;
         conflict_q     <= conflict_d;
         idx_q          <= idx_d;
         wdata_q        <= wdata_d;
         read_data_q    <= read_data_d;
         rsp_valid_q    <= rsp_valid_d;
         misaligned_q   <= misaligned_d;
         req_conflict_q <= req_conflict_d;
      end
   end

   // Storage array; never cleared, and a write colliding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && w_mem_we) begin
         mem_q[idx_d] <= wdata_d;
      end
   end

   assign READ_DATA    = read_data_q;
   assign rsp_valid    = rsp_valid_q;
   assign mem_busy     = w_mem_busy;
   assign misaligned   = misaligned_q;
   assign req_conflict = req_conflict_q;

endmodule
`default_nettype wire
